// File: rtl/cpu_test_reporter_if.sv
// CPU-side signal bundle for the self-test reporter.
// The master side (CPU core / stimulus) drives test control and CPU activity;
// the slave side (reporter) returns the run enable and the pass counter.
interface cpu_test_reporter_if;
  logic        start_i;
  logic [31:0] cpu_pc_i;
  logic        cpu_retire_i;
  logic        assert_valid_i;
  logic        assert_pass_i;
  logic        done_i;
  logic        cpu_run_o;
  logic [15:0] pass_count_o;

  modport master (
    output start_i, cpu_pc_i, cpu_retire_i, assert_valid_i, assert_pass_i, done_i,
    input  cpu_run_o, pass_count_o
  );

  modport slave (
    input  start_i, cpu_pc_i, cpu_retire_i, assert_valid_i, assert_pass_i, done_i,
    output cpu_run_o, pass_count_o
  );
endinterface

// File: rtl/cpu_test_reporter.sv
// Self-test status reporter: sequences idle -> arm -> run -> pass/fail and
// publishes a 6-bit status code plus the CPU PC on the user I/O pins.
module cpu_test_reporter #(
  parameter int unsigned START_DELAY    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65536,
  parameter logic [5:0]  CODE_START     = 6'h18,
  parameter logic [5:0]  CODE_PASS      = 6'h19,
  parameter logic [5:0]  CODE_FAIL      = 6'h1a
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  cpu_test_reporter_if.slave   bus,
  output logic [37:0]          io_out,
  output logic [37:0]          io_oeb
);

  localparam int unsigned DlyW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [DlyW-1:0] DlyLoad = DlyW'(START_DELAY - 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StArm, StRun, StPass, StFail} state_e;

  state_e            state_q;
  logic [5:0]        code_q;
  logic [26:0]       pc_q;
  logic              run_q;
  logic [15:0]       pass_q;
  logic [DlyW-1:0]   dly_q;
  logic [TmoW-1:0]   tmo_q;
  logic              timeout_hit;
  logic              assert_fail;
  logic              unused_pc_low;

  // Low PC bits share pins with housekeeping and are never reported.
  assign unused_pc_low = ^bus.cpu_pc_i[4:0];

  // A zero TIMEOUT_CYCLES disables the watchdog entirely.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tmo_q == TmoLast);
  assign assert_fail = bus.assert_valid_i && !bus.assert_pass_i;

  // Test sequencer; code and PC are updated on the same edge so the monitor sees them together.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
      code_q  <= '0;
      pc_q    <= '0;
      run_q   <= 1'b0;
      pass_q  <= '0;
      dly_q   <= '0;
      tmo_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start_i) begin
            state_q <= StArm;
            dly_q   <= DlyLoad;
          end
        end
        StArm: begin
          if (!bus.start_i) begin
            state_q <= StIdle;
          end else if (dly_q == '0) begin
            state_q <= StRun;
            code_q  <= CODE_START;
            run_q   <= 1'b1;
            tmo_q   <= '0;
          end else begin
            dly_q <= dly_q - 1'b1;
          end
        end
        StRun: begin
          if (bus.assert_valid_i && bus.assert_pass_i && (pass_q != 16'hFFFF)) begin
            pass_q <= pass_q + 16'd1;
          end
          // Failing assertion beats timeout beats done beats a plain retire.
          if (assert_fail) begin
            state_q <= StFail;
            code_q  <= CODE_FAIL;
            run_q   <= 1'b0;
            pc_q    <= bus.cpu_pc_i[31:5];
          end else if (timeout_hit) begin
            state_q <= StFail;
            code_q  <= CODE_FAIL;
            run_q   <= 1'b0;
          end else if (bus.done_i) begin
            state_q <= StPass;
            code_q  <= CODE_PASS;
            run_q   <= 1'b0;
            pc_q    <= bus.cpu_pc_i[31:5];
          end else begin
            if (bus.cpu_retire_i) begin
              pc_q <= bus.cpu_pc_i[31:5];
            end
            tmo_q <= tmo_q + 1'b1;
          end
        end
        // Terminal states hold everything until reset.
        StPass, StFail: begin
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.cpu_run_o    = run_q;
  assign bus.pass_count_o = pass_q;
  assign io_out           = {code_q, pc_q, 5'b0};
  assign io_oeb           = {33'b0, 5'b11111};

endmodule

// File: tb/tb_cpu_test_reporter.sv
// Self-checking bench for cpu_test_reporter; expected status snapshots are
// queued when stimulus is driven and compared when the DUT reflects them.
module tb_cpu_test_reporter;

  localparam int unsigned StartDelay = 16;
  localparam int unsigned Timeout    = 32;

  typedef struct packed {
    logic [5:0]  code;
    logic [26:0] pc;
    logic        run;
    logic [15:0] cnt;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [37:0] io_out;
  logic [37:0] io_oeb;
  int          errors;
  int          checks;
  exp_t        exp_q[$];

  cpu_test_reporter_if bus ();

  cpu_test_reporter #(
    .START_DELAY    (StartDelay),
    .TIMEOUT_CYCLES (Timeout)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus.slave),
    .io_out   (io_out),
    .io_oeb   (io_oeb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic exp_t observed();
    exp_t o;
    o.code = io_out[37:32];
    o.pc   = io_out[31:5];
    o.run  = bus.cpu_run_o;
    o.cnt  = bus.pass_count_o;
    return o;
  endfunction

  function automatic exp_t mk(logic [5:0] code, logic [31:0] pc, logic run, logic [15:0] cnt);
    exp_t e;
    e.code = code;
    e.pc   = pc[31:5];
    e.run  = run;
    e.cnt  = cnt;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cpu_pc_i       = '0;
    bus.cpu_retire_i   = 1'b0;
    bus.assert_valid_i = 1'b0;
    bus.assert_pass_i  = 1'b0;
    bus.done_i         = 1'b0;
  endtask

  // Reset, then raise start and wait out arm; returns the edges taken to reach RUN.
  task automatic enter_run(output int n);
    idle_inputs();
    bus.start_i = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.start_i = 1'b1;
    n = 0;
    while (io_out[37:32] !== 6'h18 && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    exp_t e, o;
    idle_inputs();
    bus.start_i = 1'b0;
    rst = 1'b1;
    repeat (4) step();
    exp_q.push_back(mk(6'h00, 32'h0, 1'b0, 16'h0));
    e = exp_q.pop_front();
    o = observed();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL reset_state: got %h want %h", o, e);
    end
    checks++;
    if (io_oeb !== 38'h00_0000_001f) begin
      errors++;
      $display("FAIL io_oeb: got %h want %h", io_oeb, 38'h00_0000_001f);
    end
    checks++;
    if (io_out[4:0] !== 5'b0) begin
      errors++;
      $display("FAIL io_out_low: got %h want 00", io_out[4:0]);
    end
    rst = 1'b0;
  endtask

  task automatic test_start();
    int bad;
    bad = 0;
    bus.start_i = 1'b1;
    // First edge enters ARM, then START_DELAY cycles of ARM with code 00.
    for (int k = 1; k <= StartDelay; k++) begin
      step();
      if (io_out[37:32] !== 6'h00 || bus.cpu_run_o !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL arm_hold: got %0d early transitions, want 0", bad);
    end
    step();
    checks++;
    if (io_out[37:32] !== 6'h18 || bus.cpu_run_o !== 1'b1) begin
      errors++;
      $display("FAIL run_entry: got code %h run %b want 18 1", io_out[37:32], bus.cpu_run_o);
    end
  endtask

  task automatic test_done_pass();
    int n, bad;
    exp_t e, o;
    enter_run(n);
    checks++;
    if (n != StartDelay + 1) begin
      errors++;
      $display("FAIL run_latency: got %0d want %0d", n, StartDelay + 1);
    end
    bad = 0;
    for (int p = 32'h100; p <= 32'h140; p += 4) begin
      bus.cpu_retire_i = 1'b1;
      bus.cpu_pc_i     = p;
      exp_q.push_back(mk(6'h18, p, 1'b1, 16'h0));
      step();
      e = exp_q.pop_front();
      o = observed();
      if (o !== e) begin
        bad++;
        $display("FAIL retire_pc: got %h want %h", o, e);
      end
    end
    checks++;
    if (bad != 0) errors++;
    bus.cpu_retire_i = 1'b0;
    bus.done_i       = 1'b1;
    bus.cpu_pc_i     = 32'h144;
    exp_q.push_back(mk(6'h19, 32'h144, 1'b0, 16'h0));
    step();
    idle_inputs();
    e = exp_q.pop_front();
    o = observed();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL done_pass: got %h want %h", o, e);
    end
    // Terminal state ignores later activity.
    bus.cpu_retire_i   = 1'b1;
    bus.cpu_pc_i       = 32'hFFFF_FFE0;
    bus.assert_valid_i = 1'b1;
    bus.assert_pass_i  = 1'b0;
    exp_q.push_back(mk(6'h19, 32'h144, 1'b0, 16'h0));
    repeat (3) step();
    idle_inputs();
    e = exp_q.pop_front();
    o = observed();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL pass_sticky: got %h want %h", o, e);
    end
  endtask

  task automatic test_assert_fail();
    int n;
    exp_t e, o;
    enter_run(n);
    bus.assert_valid_i = 1'b1;
    bus.assert_pass_i  = 1'b1;
    bus.cpu_pc_i       = 32'h200;
    exp_q.push_back(mk(6'h18, 32'h0, 1'b1, 16'd3));
    repeat (3) step();
    e = exp_q.pop_front();
    o = observed();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL pass_count: got %h want %h", o, e);
    end
    bus.assert_pass_i = 1'b0;
    bus.cpu_pc_i      = 32'h2A0;
    exp_q.push_back(mk(6'h1a, 32'h2A0, 1'b0, 16'd3));
    step();
    idle_inputs();
    e = exp_q.pop_front();
    o = observed();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL assert_fail: got %h want %h", o, e);
    end
  endtask

  task automatic test_fail_beats_done();
    int n;
    exp_t e, o;
    enter_run(n);
    bus.assert_valid_i = 1'b1;
    bus.assert_pass_i  = 1'b0;
    bus.done_i         = 1'b1;
    bus.cpu_pc_i       = 32'h80;
    exp_q.push_back(mk(6'h1a, 32'h80, 1'b0, 16'h0));
    step();
    idle_inputs();
    e = exp_q.pop_front();
    o = observed();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL fail_over_done: got %h want %h", o, e);
    end
    exp_q.push_back(mk(6'h1a, 32'h80, 1'b0, 16'h0));
    for (int k = 0; k < 2; k++) begin
      bus.done_i   = 1'b1;
      bus.cpu_pc_i = 32'h400;
      step();
      bus.done_i = 1'b0;
      step();
    end
    e = exp_q.pop_front();
    o = observed();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL fail_sticky: got %h want %h", o, e);
    end
  endtask

  task automatic test_timeout();
    int n;
    exp_t e, o;
    enter_run(n);
    bus.cpu_retire_i = 1'b1;
    bus.cpu_pc_i     = 32'h3E0;
    exp_q.push_back(mk(6'h1a, 32'h3E0, 1'b0, 16'h0));
    step();
    idle_inputs();
    n = 1;
    while (io_out[37:32] === 6'h18 && n < 64) begin
      step();
      n++;
    end
    checks++;
    if (n != Timeout) begin
      errors++;
      $display("FAIL timeout_cycles: got %0d want %0d", n, Timeout);
    end
    e = exp_q.pop_front();
    o = observed();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL timeout_state: got %h want %h", o, e);
    end
  endtask

  task automatic test_reset_and_abort();
    int n;
    exp_t e, o;
    enter_run(n);
    bus.assert_valid_i = 1'b1;
    bus.assert_pass_i  = 1'b1;
    repeat (2) step();
    idle_inputs();
    checks++;
    if (bus.pass_count_o !== 16'd2) begin
      errors++;
      $display("FAIL pre_reset_count: got %0d want 2", bus.pass_count_o);
    end
    rst = 1'b1;
    exp_q.push_back(mk(6'h00, 32'h0, 1'b0, 16'h0));
    step();
    rst = 1'b0;
    e = exp_q.pop_front();
    o = observed();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL mid_run_reset: got %h want %h", o, e);
    end
    // start_i still high: enter ARM, then drop it partway.
    repeat (5) step();
    bus.start_i = 1'b0;
    step();
    checks++;
    if (io_out[37:32] !== 6'h00 || bus.cpu_run_o !== 1'b0) begin
      errors++;
      $display("FAIL arm_abort: got code %h run %b want 00 0", io_out[37:32], bus.cpu_run_o);
    end
    // A full restart proves the counter was abandoned and reloads.
    bus.start_i = 1'b1;
    n = 0;
    while (io_out[37:32] !== 6'h18 && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (n != StartDelay + 1) begin
      errors++;
      $display("FAIL restart_latency: got %0d want %0d", n, StartDelay + 1);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.start_i = 1'b0;
    idle_inputs();
    test_reset();
    test_start();
    test_done_pass();
    test_assert_fail();
    test_fail_beats_done();
    test_timeout();
    test_reset_and_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
